mux_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing the 16-bit 8:1 datapath mux among 8 requesters.
- Drives the mux select (sel[2:0]) and a one-hot grant back to the requesters.
- A granted requester holds the shared bus for a multi-cycle transfer and releases it with done.
- Sits between requesting units (ALU result, memory read, immediate, PC+1, etc.) and the mux16_8_1 select input.

---
 rtl/mux_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit 8:1 datapath mux: drives the registered
// one-hot grant and mux select. Optional hold-limit revocation under `ARB_TIMEOUT_EN.
module mux_bus_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             timeout
);

    // Reject builds the 3-bit select or the 8-bit hold counter cannot represent.
    if (N_REQ != 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("mux_bus_arbiter: N_REQ must be 8 and MAX_HOLD in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       last_q, last_d;
    logic [3:0]       win_idle;
    logic [3:0]       win_rel;
    logic             release_now;
    logic             to_cond;

    // Returns {found, index} of the first set bit scanning cyclically from last+1.
    function automatic logic [3:0] pick(input logic [N_REQ-1:0] r, input logic [2:0] last);
        logic       found;
        logic [2:0] idx;
        logic [2:0] k;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = last + 3'(i);
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    assign win_idle = pick(req, last_q);
    assign win_rel  = pick(req & ~gnt_q, last_q);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign to_cond = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD)) && !done;
    assign timeout = timeout_q;
`else
    assign to_cond = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_now = done || !req[sel_q] || to_cond;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_idle[3]) begin
                    state_d           = GRANT;
                    gnt_d             = '0;
                    gnt_d[win_idle[2:0]] = 1'b1;
                    sel_d             = win_idle[2:0];
                    last_d            = win_idle[2:0];
`ifdef ARB_TIMEOUT_EN
                    hold_d = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
`ifdef ARB_TIMEOUT_EN
                    timeout_d = to_cond;
`endif
                    // Holder is masked, so a winner here is always a different requester.
                    if (win_rel[3]) begin
                        gnt_d               = '0;
                        gnt_d[win_rel[2:0]] = 1'b1;
                        sel_d               = win_rel[2:0];
                        last_d              = win_rel[2:0];
`ifdef ARB_TIMEOUT_EN
                        hold_d = 8'd1;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
`ifdef ARB_TIMEOUT_EN
                        hold_d = 8'd0;
`endif
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 3'd0;
            last_q  <= 3'd7;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter: hand-computed grant/select sequences for
// rotation, wrap-around, withdrawal, hold-limit and mid-grant reset.
module tb_mux_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_sel;
    logic [7:0] exp_gnt;

    mux_bus_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] s);
        logic [7:0] g;
        g    = 8'h00;
        g[s] = 1'b1;
        check({tag, ".gnt"}, gnt, g);
        check({tag, ".sel"}, sel, s);
        check({tag, ".busy"}, busy, 1'b1);
    endtask

    task automatic check_idle(input string tag, input logic [2:0] s);
        check({tag, ".gnt"}, gnt, 8'h00);
        check({tag, ".sel"}, sel, s);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (2) tick();
        check_idle("reset", 3'd0);
        check("reset.timeout", timeout, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single requester: 1-cycle latency, release to idle keeps sel.
        req = 8'h01;
        tick();
        check_grant("single", 3'd0);
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle("single_rel", 3'd0);

        // Full rotation, pointer starts at 0 so the first grant is 1.
        for (int i = 1; i <= 9; i++) exp_q.push_back(3'(i));
        req = 8'hFF;
        tick();
        while (exp_q.size() > 0) begin
            exp_sel = exp_q.pop_front();
            check_grant("rot", exp_sel);
            check("rot.timeout", timeout, 1'b0);
            if (exp_q.size() == 0) break;
            tick();
            check_grant("rot_hold", exp_sel);
            tick();
            check_grant("rot_hold2", exp_sel);
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle("rot_end", 3'd1);

        // Done while idle is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle("idle_done", 3'd1);

        // Pointer to 5, then wrap past 7 over requesters 1,2,5.
        req = 8'h20;
        tick();
        check_grant("ptr5", 3'd5);
        req  = 8'b0010_0110;
        done = 1'b1;
        tick();
        check_grant("wrap1", 3'd1);
        tick();
        check_grant("wrap2", 3'd2);
        tick();
        check_grant("wrap5", 3'd5);
        req = 8'h00;
        tick();
        done = 1'b0;
        check_idle("wrap_end", 3'd5);

        // Holder 3 withdraws while 6 waits: direct handover without done.
        req = 8'h08;
        tick();
        check_grant("w3", 3'd3);
        req = 8'h40;
        tick();
        check_grant("w6", 3'd6);
        req = 8'h00;
        tick();
        check_idle("w_end", 3'd6);

        // Hold limit: requester 0 first (pointer 6), requester 1 waiting.
        req = 8'h03;
        tick();
        check_grant("hold0", 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("hold_n", 3'd0);
            check("hold_n.timeout", timeout, 1'b0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check_grant("to_rev", 3'd1);
        check("to_rev.timeout", timeout, 1'b1);
        tick();
        check_grant("to_after", 3'd1);
        check("to_after.timeout", timeout, 1'b0);
        exp_sel = 3'd1;
`else
        check_grant("no_to", 3'd0);
        check("no_to.timeout", timeout, 1'b0);
        tick();
        check_grant("no_to2", 3'd0);
        check("no_to2.timeout", timeout, 1'b0);
        exp_sel = 3'd0;
`endif
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle("to_end", exp_sel);

        // Mid-grant asynchronous reset, then regrant from pointer 7.
        req = 8'h10;
        tick();
        check_grant("pre_rst", 3'd4);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst", 3'd0);
        tick();
        check_idle("in_rst", 3'd0);
        rst_n = 1'b1;
        tick();
        exp_gnt = 8'h10;
        check("post_rst.gnt", gnt, exp_gnt);
        check("post_rst.sel", sel, 3'd4);
        req  = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
        check_idle("final", 3'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
